normalize32_seq: RTL and testbench

Multi-cycle 32-bit normalizer: the inverse of the barrel shift path. The barrel shifter applies a given shift amount; this block derives the shift amount from the data by shifting a word until its MSB (or LSB) is set. It returns the normalized word and the shift count that produced it. It sits beside the ALU shift path and feeds leading/trailing-zero counts and normalized operands to later datapath stages. It uses a fixed 5-step binary search (16, 8, 4, 2, 1), so latency is constant.

---
 rtl/normalize32_seq.sv | 124 ++++++++++++
 tb/tb_normalize32_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/normalize32_seq.sv
// normalize32_seq: multi-cycle 32-bit normalizer (5-step binary search).
// Ports: CLK, RST (async, active-low), START, D, LnR -> Y, CNT, ZERO, BUSY, DONE.
// Macro NORM32_TZ_EN builds right (trailing-zero) normalization; else left only.
module normalize32_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] D,
  input  logic        LnR,
  output logic [31:0] Y,
  output logic [5:0]  CNT,
  output logic        ZERO,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] w;
  logic [31:0] w_step;
  logic [4:0]  acc;
  logic [4:0]  acc_step;
  logic [2:0]  idx;
  logic [4:0]  s;
  logic        zflag;
  logic        hi_zero;
  logic        accept;
  logic        last_step;
`ifdef NORM32_TZ_EN
  logic        dir;
  logic        lo_zero;
`else
  logic        unused_lnr;
  assign unused_lnr = LnR;
`endif

  assign accept    = (state == S_IDLE) && START;
  assign last_step = (state == S_SHIFT) && (idx == 3'd4);

  // One binary-search step: shift by s only if the s bits
  // that would fall off the end are all zero.
  always_comb begin
    s        = 5'd16 >> idx;
    hi_zero  = (w & ~(32'hFFFF_FFFF >> s)) == 32'h0;
    w_step   = w;
    acc_step = acc;
`ifdef NORM32_TZ_EN
    lo_zero  = (w & ~(32'hFFFF_FFFF << s)) == 32'h0;
    if (dir) begin
      if (hi_zero) begin
        w_step   = w << s;
        acc_step = acc + s;
      end
    end else begin
      if (lo_zero) begin
        w_step   = w >> s;
        acc_step = acc + s;
      end
    end
`else
    if (hi_zero) begin
      w_step   = w << s;
      acc_step = acc + s;
    end
`endif
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (START) state_nx = S_SHIFT;
      S_SHIFT: if (idx == 3'd4) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign BUSY = (state != S_IDLE);
  assign DONE = (state == S_DONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      w     <= '0;
      acc   <= '0;
      idx   <= '0;
      zflag <= 1'b0;
      Y     <= '0;
      CNT   <= '0;
      ZERO  <= 1'b0;
`ifdef NORM32_TZ_EN
      dir   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        w     <= D;
        acc   <= '0;
        idx   <= '0;
        zflag <= (D == 32'h0);
`ifdef NORM32_TZ_EN
        dir   <= LnR;
`endif
      end else if (state == S_SHIFT) begin
        w   <= w_step;
        acc <= acc_step;
        idx <= idx + 3'd1;
      end
      // Results load from the final step's value, not the stale w.
      if (last_step) begin
        Y    <= w_step;
        CNT  <= zflag ? 6'd32 : {1'b0, acc_step};
        ZERO <= zflag;
      end
    end
  end

endmodule

// File: tb/tb_normalize32_seq.sv
// tb_normalize32_seq: randomized self-checking bench for normalize32_seq.
// Reference model counts zeros bit by bit; honours NORM32_TZ_EN.
module tb_normalize32_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [31:0] D = '0;
  logic        LnR = 1'b0;
  logic [31:0] Y;
  logic [5:0]  CNT;
  logic        ZERO;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int failures = 0;

  normalize32_seq dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .D    (D),
    .LnR  (LnR),
    .Y    (Y),
    .CNT  (CNT),
    .ZERO (ZERO),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] d, input logic lnr,
                                output logic [31:0] y, output int c);
    logic left;
`ifdef NORM32_TZ_EN
    left = lnr;
`else
    left = 1'b1;
`endif
    y = d;
    c = 0;
    if (d == 32'h0) begin
      c = 32;
    end else if (left) begin
      while (!y[31]) begin
        y = y << 1;
        c++;
      end
    end else begin
      while (!y[0]) begin
        y = y >> 1;
        c++;
      end
    end
  endfunction

  task automatic run_op(input logic [31:0] d, input logic lnr);
    logic [31:0] ey;
    int          ec;
    int          n;
    int          guard;
    model(d, lnr, ey, ec);
    guard = 0;
    @(negedge CLK);
    while (BUSY && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    chk("idle_wait", 64'(BUSY), 64'd0);
    D = d;
    LnR = lnr;
    START = 1'b1;
    @(posedge CLK);
    #1;
    chk("busy_accept", 64'(BUSY), 64'd1);
    chk("done_accept", 64'(DONE), 64'd0);
    @(negedge CLK);
    START = 1'b0;
    D = $urandom;
    LnR = 1'($urandom);
    n = 0;
    while (!DONE && n < 12) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'd5);
    chk("y", 64'(Y), 64'(ey));
    chk("cnt", 64'(CNT), 64'(ec));
    chk("zero", 64'(ZERO), 64'(d == 32'h0));
    @(posedge CLK);
    #1;
    chk("done_drop", 64'(DONE), 64'd0);
    chk("busy_drop", 64'(BUSY), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          ndone;
    int          last;
    int          cyc;

    #12;
    chk("rst_y", 64'(Y), 64'd0);
    chk("rst_cnt", 64'(CNT), 64'd0);
    chk("rst_zero", 64'(ZERO), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    run_op(32'h0000_0001, 1'b1);
    run_op(32'h8000_0000, 1'b1);
    run_op(32'h0000_0000, 1'b1);
    run_op(32'h0000_0000, 1'b0);
    run_op(32'h0001_0000, 1'b0);
    run_op(32'h0000_0001, 1'b0);
    run_op(32'h8000_0000, 1'b0);
    run_op(32'hFFFF_FFFF, 1'b1);

    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      if ($urandom_range(0, 1) == 0)
        d = d >> $urandom_range(0, 31);
      else
        d = d << $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0)
        d = 32'h0;
      run_op(d, 1'($urandom));
    end

    // START held high; D scrambled while an operation is in flight.
    @(negedge CLK);
    D = 32'h00F0_0000;
    LnR = 1'b1;
    START = 1'b1;
    ndone = 0;
    last = -1;
    for (cyc = 1; cyc <= 30; cyc++) begin
      @(posedge CLK);
      #1;
      if (DONE) begin
        ndone++;
        chk("hold_y", 64'(Y), 64'hF000_0000);
        chk("hold_cnt", 64'(CNT), 64'd8);
        if (last >= 0)
          chk("hold_gap", 64'(cyc - last), 64'd7);
        last = cyc;
      end
      if (BUSY && !DONE) begin
        D = $urandom;
      end else begin
        D = 32'h00F0_0000;
      end
    end
    chk("hold_count", 64'(ndone), 64'd4);
    @(negedge CLK);
    START = 1'b0;

    // Reset mid-operation.
    run_op(32'h0000_0F00, 1'b1);
    @(negedge CLK);
    D = $urandom | 32'h1;
    LnR = 1'b1;
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_rst_y", 64'(Y), 64'd0);
    chk("mid_rst_cnt", 64'(CNT), 64'd0);
    chk("mid_rst_zero", 64'(ZERO), 64'd0);
    chk("mid_rst_busy", 64'(BUSY), 64'd0);
    chk("mid_rst_done", 64'(DONE), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(posedge CLK);
      #1;
      if (DONE) ndone++;
    end
    chk("no_done_after_rst", 64'(ndone), 64'd0);
    run_op(32'h0000_0100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
